tag_mem_sweeper: RTL and testbench



---
 rtl/tag_mem_sweeper.sv | 200 ++++++++++++++++++++
 tb/tb_tag_mem_sweeper.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_mem_sweeper.sv
// Tag RAM sweeper: clears, sets or scans a contiguous range of taint tag words
// through the tag RAM's single port, reporting the tainted-byte count and first hit.
module tag_mem_sweeper #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = ADDR_WIDTH - $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [1:0]                    cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]          cmd_len_i,
  input  logic                          abort_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [ADDR_WIDTH:0]           taint_cnt_o,
  output logic                          hit_valid_o,
  output logic [ADDR_WIDTH-1:0]         hit_addr_o,
  output logic                          en_o,
  output logic                          we_o,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic                          wdata_o,
  output logic [DATA_WIDTH/8-1:0]       be_o,
  input  logic [DATA_WIDTH/8-1:0]       rdata_i,
  output logic [2:0]                    state_o
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(BYTES);
  localparam int WIDX_W = ADDR_WIDTH - OFS;

  localparam logic [1:0] OP_SCAN = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [WIDX_W-1:0]     widx_q, widx_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  hv_q, hv_d;
  logic [ADDR_WIDTH-1:0] ha_q, ha_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [WIDX_W-1:0]     rd_widx_q, rd_widx_d;
  logic                  abort_act;
  logic                  accum;

  function automatic logic [OFS:0] popcnt(input logic [BYTES-1:0] v);
    logic [OFS:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) r = r + {{OFS{1'b0}}, v[i]};
    return r;
  endfunction

  function automatic logic [OFS-1:0] lowbit(input logic [BYTES-1:0] v);
    logic [OFS-1:0] r;
    r = '0;
    for (int i = BYTES - 1; i >= 0; i--) if (v[i]) r = OFS'(i);
    return r;
  endfunction

  // Handshake: a command transfers on a rising edge where cmd_valid_i and
  // cmd_ready_o are both high; cmd_ready_o is high only in IDLE.
  assign abort_act = abort_i && (state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN);
  // Data returning for a read is dropped when the command is aborted that cycle.
  assign accum     = rd_pend_q && !abort_act;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    widx_d    = widx_q;
    rem_d     = rem_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    hv_d      = hv_q;
    ha_d      = ha_q;
    rd_pend_d = 1'b0;
    rd_widx_d = rd_widx_q;
    en_o      = 1'b0;
    we_o      = 1'b0;
    addr_o    = '0;
    wdata_o   = 1'b0;
    be_o      = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          widx_d = cmd_addr_i[ADDR_WIDTH-1:OFS];
          rem_d  = cmd_len_i;
          err_d  = 1'b0;
          if (cmd_op_i == OP_SCAN) begin
            cnt_d = '0;
            hv_d  = 1'b0;
          end
          if (cmd_op_i == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cmd_len_i == '0) begin
            state_d = S_DONE;
          end else if (cmd_op_i == OP_SCAN) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        en_o    = 1'b1;
        we_o    = 1'b1;
        be_o    = '1;
        addr_o  = {widx_q, {OFS{1'b0}}};
        wdata_o = op_q[0];
        widx_d  = widx_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == LEN_WIDTH'(1)) begin
          state_d = S_DONE;
        end
      end
      S_READ: begin
        en_o      = 1'b1;
        addr_o    = {widx_q, {OFS{1'b0}}};
        rd_pend_d = !abort_i;
        rd_widx_d = widx_q;
        widx_d    = widx_q + 1'b1;
        rem_d     = rem_q - 1'b1;
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == LEN_WIDTH'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_i) err_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accum) begin
      cnt_d = cnt_q + {{(ADDR_WIDTH - OFS){1'b0}}, popcnt(rdata_i)};
      if (!hv_q && rdata_i != '0) begin
        hv_d = 1'b1;
        ha_d = {rd_widx_q, lowbit(rdata_i)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      widx_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      hv_q      <= 1'b0;
      ha_q      <= '0;
      rd_pend_q <= 1'b0;
      rd_widx_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      widx_q    <= widx_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      hv_q      <= hv_d;
      ha_q      <= ha_d;
      rd_pend_q <= rd_pend_d;
      rd_widx_q <= rd_widx_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign taint_cnt_o = cnt_q;
  assign hit_valid_o = hv_q;
  assign hit_addr_o  = ha_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_tag_mem_sweeper.sv
// Bench for tag_mem_sweeper: directed commands against a behavioural tag RAM,
// with RAM accesses and done reports checked by a queue-based monitor.
module tb_tag_mem_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        preload = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = '0;
  logic [15:0] cmd_addr_i = '0;
  logic [14:0] cmd_len_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [16:0] taint_cnt_o;
  logic        hit_valid_o;
  logic [15:0] hit_addr_o;
  logic        en_o, we_o, wdata_o;
  logic [15:0] addr_o;
  logic [3:0]  be_o;
  logic [3:0]  rdata_i = '0;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;

  // {cycle, we, addr, wdata, be}
  logic [53:0] acc_q[$];
  // {cycle, err, cnt, hit_valid, hit_addr}
  logic [66:0] done_q[$];

  logic [3:0] mem [0:16383];

  tag_mem_sweeper dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .taint_cnt_o(taint_cnt_o),
    .hit_valid_o(hit_valid_o), .hit_addr_o(hit_addr_o),
    .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rdata_i(rdata_i), .state_o(state_o)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural tag RAM with registered read data
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 4'h0;
      for (int i = 4; i < 8; i++) mem[i] <= 4'hF;
      mem[9]     <= 4'b0100;
      mem[10]    <= 4'b0100;
      mem[1]     <= 4'b1000;
      mem[16382] <= 4'b0010;
      mem[0]     <= 4'b0001;
    end else if (en_o) begin
      if (we_o) begin
        for (int b = 0; b < 4; b++) if (be_o[b]) mem[addr_o[15:2]][b] <= wdata_o;
      end else begin
        rdata_i <= mem[addr_o[15:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (en_o) begin
      if (acc_q.size() == 0) begin
        chk("unexpected_access", {cyc, we_o, addr_o, wdata_o, be_o}, '0);
      end else begin
        chk("ram_access", {cyc, we_o, addr_o, wdata_o, be_o}, acc_q.pop_front());
      end
    end else begin
      chk("idle_ram_outputs", {we_o, addr_o, wdata_o, be_o}, '0);
    end
    if (done_o) begin
      done_cnt++;
      chk("done_ready_busy", {cmd_ready_o, busy_o}, 2'b01);
      if (done_q.size() == 0) begin
        chk("unexpected_done", {cyc, err_o, taint_cnt_o, hit_valid_o, hit_addr_o}, '0);
      end else begin
        chk("done_status", {cyc, err_o, taint_cnt_o, hit_valid_o, hit_addr_o}, done_q.pop_front());
      end
    end
  end

  // driver: issue one command, push expectations, optionally abort, wait for done
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [14:0] len,
                         input int n_acc, input int done_off, input int abort_at,
                         input logic e_err, input logic [16:0] e_cnt, input logic e_hv,
                         input logic [15:0] e_ha);
    int a;
    int d0;
    int k;
    logic [13:0] base;
    logic        is_wr;
    @(negedge clk);
    a     = cyc;
    d0    = done_cnt;
    base  = addr[15:2];
    is_wr = (op == 2'b00 || op == 2'b01);
    chk("cmd_ready_idle", cmd_ready_o, 1'b1);
    for (int i = 0; i < n_acc; i++)
      acc_q.push_back({32'(a + 1 + i), is_wr, 14'(base + 14'(i)), 2'b00,
                       is_wr ? op[0] : 1'b0, is_wr ? 4'hF : 4'h0});
    done_q.push_back({32'(a + done_off), e_err, e_cnt, e_hv, e_ha});
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1 abort_i = 1'b1;
      @(posedge clk);
      #1 abort_i = 1'b0;
    end
    k = 0;
    while (done_cnt == d0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", done_cnt != d0, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    chk("reset_handshake", {cmd_ready_o, busy_o, done_o, err_o, state_o}, {4'b1000, 3'd0});
    chk("reset_status", {taint_cnt_o, hit_valid_o, hit_addr_o}, '0);
    chk("reset_ram", {en_o, we_o, addr_o, wdata_o, be_o}, '0);

    // clear 4 words over preset F tags, then scan them back
    run_cmd(2'b00, 16'h0010, 15'd4, 4, 5, 0, 1'b0, 17'd0, 1'b0, 16'h0000);
    run_cmd(2'b10, 16'h0010, 15'd4, 4, 6, 0, 1'b0, 17'd0, 1'b0, 16'h0000);
    // set 2 words at 0x20, scan 0x1C..0x28 (0x28 holds 4'b0100)
    run_cmd(2'b01, 16'h0020, 15'd2, 2, 3, 0, 1'b0, 17'd0, 1'b0, 16'h0000);
    run_cmd(2'b10, 16'h001C, 15'd4, 4, 6, 0, 1'b0, 17'd9, 1'b1, 16'h0020);
    // unaligned single-word scan
    run_cmd(2'b10, 16'h0006, 15'd1, 1, 3, 0, 1'b0, 17'd1, 1'b1, 16'h0007);
    // wrapping scan
    run_cmd(2'b10, 16'hFFF8, 15'd3, 3, 5, 0, 1'b0, 17'd2, 1'b1, 16'hFFF9);
    // aborted set after 3 writes; status holds previous scan values
    run_cmd(2'b01, 16'h0100, 15'd8, 3, 4, 3, 1'b1, 17'd2, 1'b1, 16'hFFF9);
    run_cmd(2'b10, 16'h0100, 15'd4, 4, 6, 0, 1'b0, 17'd12, 1'b1, 16'h0100);
    // zero length, then reserved op
    run_cmd(2'b01, 16'h0200, 15'd0, 0, 1, 0, 1'b0, 17'd12, 1'b1, 16'h0100);
    run_cmd(2'b11, 16'h0200, 15'd5, 0, 1, 0, 1'b1, 17'd12, 1'b1, 16'h0100);

    // reset in the middle of an 8-word scan
    @(negedge clk);
    a = cyc;
    chk("cmd_ready_idle", cmd_ready_o, 1'b1);
    for (int i = 0; i < 3; i++)
      acc_q.push_back({32'(a + 1 + i), 1'b0, 14'(14'h40 + 14'(i)), 2'b00, 1'b0, 4'h0});
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b10;
    cmd_addr_i  = 16'h0100;
    cmd_len_i   = 15'd8;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_handshake", {cmd_ready_o, busy_o, done_o, err_o, state_o}, {4'b1000, 3'd0});
    chk("midreset_status", {taint_cnt_o, hit_valid_o, hit_addr_o}, '0);
    chk("midreset_en", en_o, 1'b0);
    repeat (12) @(posedge clk);

    @(negedge clk);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
